// File: rtl/palette_loader.sv
// palette_loader
// ---------------
// Streams a palette file from the host download channel into the video
// stage's writable palette RAM. Each R,G,B byte triple from the host is
// packed into one 24-bit entry. Entries are buffered in a small FIFO and
// drained through the load_color write port, at most one entry per cycle.
//
// Optional feature macro: PALETTE_VBLANK_GATE_EN
//   defined     : the FIFO drains only while the registered vblank is high.
//   not defined : the drain gate is always open and vblank_i is unused.
//
// Ports
//   clk                 in   system clock (shared with the video stage)
//   reset               in   synchronous, active-high reset
//   ioctl_download_i    in   high for the duration of a palette download
//   ioctl_wr_i          in   one-cycle byte strobe
//   ioctl_dout_i        in   download byte, order R,G,B per entry
//   ioctl_wait_o        out  backpressure to the host, high while FIFO full
//   vblank_i            in   vertical blanking from the video timing
//   load_color_o        out  one-cycle palette RAM write strobe
//   load_color_data_o   out  packed entry {R,G,B}, held until next write
//   load_color_index_o  out  palette index, held until next write
//   loaded_count_o      out  entries written since the last download start
//   done_o              out  all accepted entries have been written (level)
//   overflow_o          out  sticky: an entry was dropped on a full FIFO
//
// Host handshake: a byte is transferred in every cycle where ioctl_wr_i is
// high. ioctl_wait_o is a combinational "not ready" flag; the host must hold
// off strobing while it is high. A strobe that ignores it still counts toward
// the triple, but a completed entry that finds the FIFO full is dropped.

module palette_loader #(
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download_i,
    input  logic        ioctl_wr_i,
    input  logic [7:0]  ioctl_dout_i,
    output logic        ioctl_wait_o,
    input  logic        vblank_i,
    output logic        load_color_o,
    output logic [23:0] load_color_data_o,
    output logic [5:0]  load_color_index_o,
    output logic [6:0]  loaded_count_o,
    output logic        done_o,
    output logic        overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [6:0]    NUM_C   = 7'(NUM_ENTRIES);

    typedef struct packed {
        logic [5:0]  index;
        logic [23:0] rgb;
    } entry_t;

    // Host side
    logic          dl_q;
    logic [1:0]    phase_q, phase_d;
    logic [6:0]    idx_q, idx_d;
    logic [7:0]    r_q, r_d;
    logic [7:0]    g_q, g_d;

    // FIFO
    entry_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // Output side
    logic          load_color_q;
    logic [23:0]   data_q;
    logic [5:0]    index_q;
    logic [6:0]    loaded_count_q;
    logic          done_q;
    logic          overflow_q;

    logic          start, fall, gate, push, pop, drop, done_set;
    entry_t        push_entry;

`ifdef PALETTE_VBLANK_GATE_EN
    logic vblank_q;
    always_ff @(posedge clk) begin
        if (reset) vblank_q <= 1'b0;
        else       vblank_q <= vblank_i;
    end
    assign gate = vblank_q;
`else
    logic unused_vblank;
    assign unused_vblank = vblank_i;
    assign gate = 1'b1;
`endif

    assign start = ioctl_download_i & ~dl_q;
    assign fall  = ~ioctl_download_i & dl_q;

    always_comb begin
        // A download start clears host and FIFO state in the same cycle, so
        // every "current" value below starts from the cleared view.
        phase_d    = start ? 2'd0 : phase_q;
        idx_d      = start ? 7'd0 : idx_q;
        wr_ptr_d   = start ? '0 : wr_ptr_q;
        rd_ptr_d   = start ? '0 : rd_ptr_q;
        count_d    = start ? '0 : count_q;
        r_d        = r_q;
        g_d        = g_q;
        push       = 1'b0;
        drop       = 1'b0;
        push_entry = '{index: idx_q[5:0], rgb: {r_q, g_q, ioctl_dout_i}};

        pop = ~start & (count_q != '0) & gate;

        // A half-assembled triple is abandoned when the download ends.
        if (fall) phase_d = 2'd0;

        if (ioctl_wr_i && ioctl_download_i && (idx_d < NUM_C)) begin
            case (phase_d)
                2'd0: begin
                    r_d     = ioctl_dout_i;
                    phase_d = 2'd1;
                end
                2'd1: begin
                    g_d     = ioctl_dout_i;
                    phase_d = 2'd2;
                end
                default: begin
                    phase_d = 2'd0;
                    idx_d   = idx_d + 7'd1;
                    // A same-cycle pop frees the slot, so a full FIFO still accepts.
                    if ((count_d != DEPTH_C) || pop) push = 1'b1;
                    else                             drop = 1'b1;
                end
            endcase
        end

        if (push) wr_ptr_d = wr_ptr_d + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_d + AW'(1);
        if (push && !pop)      count_d = count_d + (AW+1)'(1);
        else if (pop && !push) count_d = count_d - (AW+1)'(1);
    end

    // A pop implies a non-empty FIFO, so an empty FIFO also means no write
    // is about to be issued; loaded_count already includes the last pulse.
    assign done_set = ~ioctl_download_i & (count_q == '0) & (loaded_count_q != 7'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_q           <= 1'b0;
            phase_q        <= 2'd0;
            idx_q          <= 7'd0;
            r_q            <= 8'd0;
            g_q            <= 8'd0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            load_color_q   <= 1'b0;
            data_q         <= 24'd0;
            index_q        <= 6'd0;
            loaded_count_q <= 7'd0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            dl_q         <= ioctl_download_i;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            r_q          <= r_d;
            g_q          <= g_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            load_color_q <= pop;
            if (pop) begin
                data_q  <= mem_q[rd_ptr_q].rgb;
                index_q <= mem_q[rd_ptr_q].index;
            end
            if (start)    loaded_count_q <= 7'd0;
            else if (pop) loaded_count_q <= loaded_count_q + 7'd1;
            if (start)         done_q <= 1'b0;
            else if (done_set) done_q <= 1'b1;
            if (start)     overflow_q <= 1'b0;
            else if (drop) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: occupancy and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign ioctl_wait_o       = (count_q == DEPTH_C);
    assign load_color_o       = load_color_q;
    assign load_color_data_o  = data_q;
    assign load_color_index_o = index_q;
    assign loaded_count_o     = loaded_count_q;
    assign done_o             = done_q;
    assign overflow_o         = overflow_q;

endmodule
